// File: rtl/sig_bus_initiator.sv
// Initiator for the signal_1..signal_4 interface: one outstanding command, registered outputs.
// Optional reply/request parity is enabled with `define SIG_BUS_INIT_PARITY_EN.
module sig_bus_initiator #(
    parameter int DW      = 32,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [3*DW-1:0] cmd_data,
    output logic [DW-1:0]   signal_1,
    output logic [DW-1:0]   signal_2,
    output logic [DW-1:0]   signal_3,
    output logic            req_valid,
    input  logic            req_ready,
    input  logic [DW-1:0]   signal_4,
    input  logic            signal_4_valid,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_data,
    output logic            rsp_timeout,
`ifdef SIG_BUS_INIT_PARITY_EN
    output logic            req_parity,
    input  logic            signal_4_parity,
    output logic            rsp_perr,
`endif
    output logic [7:0]      stray_cnt
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] timer_q;
    logic            timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cmd_ready && cmd_valid) state_d = SEND;
            SEND: if (req_ready) state_d = WAIT;
            WAIT: if (signal_4_valid || timeout_hit) state_d = DONE;
            DONE: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready   <= 1'b0;
            req_valid   <= 1'b0;
            rsp_valid   <= 1'b0;
            signal_1    <= '0;
            signal_2    <= '0;
            signal_3    <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            timer_q     <= '0;
            stray_cnt   <= '0;
`ifdef SIG_BUS_INIT_PARITY_EN
            req_parity  <= 1'b0;
            rsp_perr    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_ready <= (state_d == IDLE);
            req_valid <= (state_d == SEND);
            rsp_valid <= (state_d == DONE);

            if (state_q == IDLE && state_d == SEND) begin
                signal_1 <= cmd_data[DW-1:0];
                signal_2 <= cmd_data[2*DW-1:DW];
                signal_3 <= cmd_data[3*DW-1:2*DW];
`ifdef SIG_BUS_INIT_PARITY_EN
                req_parity <= ^cmd_data;
`endif
            end

            if (state_q == SEND && req_ready)
                timer_q <= '0;
            else if (state_q == WAIT)
                timer_q <= timer_q + 1'b1;

            if (state_q == WAIT) begin
                if (signal_4_valid) begin
                    rsp_data    <= signal_4;
                    rsp_timeout <= 1'b0;
`ifdef SIG_BUS_INIT_PARITY_EN
                    rsp_perr    <= (signal_4_parity != ^signal_4);
`endif
                end else if (timeout_hit) begin
                    rsp_data    <= '0;
                    rsp_timeout <= 1'b1;
`ifdef SIG_BUS_INIT_PARITY_EN
                    rsp_perr    <= 1'b0;
`endif
                end
            end

            if (signal_4_valid && state_q != WAIT && stray_cnt != 8'hFF)
                stray_cnt <= stray_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_sig_bus_initiator.sv
// Directed bench for sig_bus_initiator with a transaction-level expectation model.
// Parity checks are compiled in with `define SIG_BUS_INIT_PARITY_EN.
module tb_sig_bus_initiator;

    localparam int DW     = 32;
    localparam int TO_CFG = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [3*DW-1:0] cmd_data;
    logic [DW-1:0]   signal_1, signal_2, signal_3;
    logic            req_valid;
    logic            req_ready;
    logic [DW-1:0]   signal_4;
    logic            signal_4_valid;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic            rsp_timeout;
    logic [7:0]      stray_cnt;
`ifdef SIG_BUS_INIT_PARITY_EN
    logic            req_parity;
    logic            signal_4_parity;
    logic            rsp_perr;
`endif

    sig_bus_initiator #(.DW(DW), .TO_W(8), .TIMEOUT(TO_CFG)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .signal_1(signal_1), .signal_2(signal_2), .signal_3(signal_3),
        .req_valid(req_valid), .req_ready(req_ready),
        .signal_4(signal_4), .signal_4_valid(signal_4_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
`ifdef SIG_BUS_INIT_PARITY_EN
        .req_parity(req_parity), .signal_4_parity(signal_4_parity), .rsp_perr(rsp_perr),
`endif
        .stray_cnt(stray_cnt)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Expectation model: last accepted command, expected reply, stray pulse count.
    logic            chk_en = 1'b0;
    logic [3*DW-1:0] exp_cmd = '0;
    logic [DW-1:0]   exp_rsp = '0;
    logic            exp_to  = 1'b0;
    int unsigned     exp_stray = 0;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_stray();
        exp_stray = (exp_stray < 255) ? exp_stray + 1 : 255;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (req_valid) begin
                check("req_payload", {signal_3, signal_2, signal_1}, exp_cmd);
`ifdef SIG_BUS_INIT_PARITY_EN
                check("req_parity", req_parity, ^exp_cmd);
`endif
            end
            if (rsp_valid) begin
                check("rsp_data", rsp_data, exp_rsp);
                check("rsp_timeout", rsp_timeout, exp_to);
            end
            check("stray_cnt", stray_cnt, exp_stray);
        end
    end

    task automatic send_cmd(input logic [3*DW-1:0] c, input logic hold_req_ready);
        bit acc = 0;
        cmd_data  = c;
        cmd_valid = 1'b1;
        req_ready = hold_req_ready;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (cmd_ready) acc = 1;
            tick();
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", acc, 1'b1);
        exp_cmd = c;
        check("req_valid_latency", req_valid, 1'b1);
        check("cmd_ready_busy", cmd_ready, 1'b0);
    endtask

    task automatic req_hs(input int stall, input logic stray_in_send);
        req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            if (stray_in_send && i == 1) begin
                signal_4_valid = 1'b1;
                signal_4 = 32'h5555_AAAA;
            end
            tick();
            if (signal_4_valid) begin
                signal_4_valid = 1'b0;
                count_stray();
            end
            check("req_valid_held", req_valid, 1'b1);
            check("cmd_ready_in_send", cmd_ready, 1'b0);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("req_valid_drop", req_valid, 1'b0);
    endtask

    // k = WAIT cycle (1-based) carrying the reply; 0 = no reply.
    task automatic reply(input int k, input logic [DW-1:0] data, input logic bad_par);
        int  n;
        bit  got_reply;
        got_reply = (k != 0) && (k <= TO_CFG);
        n = got_reply ? k : TO_CFG;
        for (int i = 1; i <= n; i++) begin
            if (i == k) begin
                signal_4_valid = 1'b1;
                signal_4 = data;
`ifdef SIG_BUS_INIT_PARITY_EN
                signal_4_parity = (^data) ^ bad_par;
`endif
            end
            tick();
            signal_4_valid = 1'b0;
            if (i < n) check("rsp_valid_early", rsp_valid, 1'b0);
        end
        exp_rsp = got_reply ? data : '0;
        exp_to  = !got_reply;
        check("rsp_valid_rise", rsp_valid, 1'b1);
`ifdef SIG_BUS_INIT_PARITY_EN
        check("rsp_perr", rsp_perr, got_reply && bad_par);
`endif
    endtask

    task automatic finish_rsp(input int hold, input logic stray_in_done);
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (stray_in_done && i == 0) begin
                signal_4_valid = 1'b1;
                signal_4 = 32'h1234_5678;
            end
            tick();
            if (signal_4_valid) begin
                signal_4_valid = 1'b0;
                count_stray();
            end
            check("rsp_valid_held", rsp_valid, 1'b1);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_drop", rsp_valid, 1'b0);
        check("cmd_ready_after_rsp", cmd_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_data = '0; req_ready = 1'b0;
        signal_4 = '0; signal_4_valid = 1'b0; rsp_ready = 1'b0;
`ifdef SIG_BUS_INIT_PARITY_EN
        signal_4_parity = 1'b0;
`endif
        tick(); tick();
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_outputs", {req_valid, rsp_valid, rsp_timeout, signal_1, signal_2, signal_3, rsp_data, stray_cnt}, '0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // 1: basic transaction with reply in the 3rd WAIT cycle
        send_cmd({32'd3, 32'd2, 32'd1}, 1'b1);
        check("t1_sig1", signal_1, 32'd1);
        check("t1_sig2", signal_2, 32'd2);
        check("t1_sig3", signal_3, 32'd3);
        req_hs(0, 1'b0);
        reply(3, 32'hCAFE_F00D, 1'b0);
        check("t1_rsp_lit", {rsp_timeout, rsp_data}, {1'b0, 32'hCAFE_F00D});
        finish_rsp(2, 1'b0);
        check("t1_sig_kept", {signal_3, signal_2, signal_1}, {32'd3, 32'd2, 32'd1});

        // 2: request backpressure, stray pulse during SEND
        send_cmd({32'hA5A5_0003, 32'h0F0F_0002, 32'h8000_0001}, 1'b0);
        req_hs(5, 1'b1);
        reply(2, 32'h0000_BEEF, 1'b0);
        finish_rsp(1, 1'b0);
        check("t2_stray_lit", stray_cnt, 8'd1);

        // 3: timeout with no reply
        send_cmd({32'd6, 32'd5, 32'd4}, 1'b0);
        req_hs(0, 1'b0);
        reply(0, '0, 1'b0);
        check("t3_timeout_lit", {rsp_timeout, rsp_data}, {1'b1, 32'd0});
        finish_rsp(1, 1'b0);

        // 4: reply on the timeout cycle wins; stray pulse in DONE leaves data alone
        send_cmd({32'd9, 32'd8, 32'd7}, 1'b0);
        req_hs(1, 1'b0);
        reply(4, 32'h1357_9BDF, 1'b0);
        check("t4_reply_wins_lit", {rsp_timeout, rsp_data}, {1'b0, 32'h1357_9BDF});
        finish_rsp(3, 1'b1);
        check("t4_stray_lit", stray_cnt, 8'd2);

        // 5: 300 stray pulses in IDLE saturate the counter
        for (int i = 0; i < 300; i++) begin
            signal_4_valid = 1'b1;
            signal_4 = 32'(i);
            tick();
            signal_4_valid = 1'b0;
            count_stray();
            tick();
        end
        check("t5_stray_sat_lit", stray_cnt, 8'd255);

        // 6: reset in WAIT, then a normal transaction
        send_cmd({32'h33, 32'h22, 32'h11}, 1'b0);
        req_hs(0, 1'b0);
        tick();
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_async", {cmd_ready, req_valid, rsp_valid, rsp_timeout, signal_1, signal_2, signal_3, rsp_data, stray_cnt}, '0);
        exp_stray = 0;
        exp_cmd = '0;
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        send_cmd({32'h77, 32'h66, 32'h55}, 1'b0);
        req_hs(0, 1'b0);
`ifdef SIG_BUS_INIT_PARITY_EN
        reply(1, 32'h0000_0007, 1'b1);
`else
        reply(1, 32'h0000_0007, 1'b0);
`endif
        check("t6_rsp_lit", rsp_data, 32'h0000_0007);
        finish_rsp(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
